// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller.
// Arbitrates D-cache misses, load-use hazards, I-cache misses and taken branches into
// per-register hold (o_Stall) and bubble-insert (o_Flush) controls plus a PC freeze.
// Optional feature: define PIPELINE_STALL_CTRL_PERF_CNT_EN to build a saturating
// stalled-cycle counter on o_Stall_Cycles; otherwise the port is tied to 0.
// i_Rst_n is expected to be release-synchronised to i_Clk by the reset generator upstream.
module pipeline_stall_ctrl #(
  parameter int unsigned N_STAGES   = 4,
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Need_Stall,
  input  logic                i_DCache_Miss,
  input  logic                i_DCache_Ready,
  input  logic                i_ICache_Miss,
  input  logic                i_ICache_Ready,
  input  logic                i_Branch_Taken,
  output logic                o_PC_Stall,
  output logic [N_STAGES-1:0] o_Stall,
  output logic [N_STAGES-1:0] o_Flush,
  output logic [1:0]          o_State,
  output logic [CNT_W-1:0]    o_Stall_Cycles
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StLu    = 2'd1,
    StDMiss = 2'd2,
    StIMiss = 2'd3
  } state_e;

  // Bubble counter wide enough for LU_BUBBLES up to 15.
  localparam int unsigned BubW = 4;
  localparam logic [BubW-1:0] BubInit = BubW'(LU_BUBBLES - 1);

  state_e          r_state;
  state_e          w_state_d;
  logic [BubW-1:0] r_bub;
  logic [BubW-1:0] w_bub_d;

  logic w_d_act;
  logic w_lu_act;
  logic w_i_act;

  // State and bubble counter registers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state <= StRun;
      r_bub   <= '0;
    end else begin
      r_state <= w_state_d;
      r_bub   <= w_bub_d;
    end
  end

  // Next-state selection; D-miss always wins, stray Ready pulses fall through as no-ops.
  always_comb begin
    w_state_d = r_state;
    w_bub_d   = r_bub;
    unique case (r_state)
      StRun: begin
        if (i_DCache_Miss) begin
          w_state_d = StDMiss;
        end else if (i_Need_Stall) begin
          w_state_d = StLu;
          w_bub_d   = BubInit;
        end else if (i_ICache_Miss) begin
          w_state_d = StIMiss;
        end
      end
      StLu: begin
        if (i_DCache_Miss) begin
          // Abort the load-use sequence; remaining bubbles are discarded.
          w_state_d = StDMiss;
          w_bub_d   = '0;
        end else if (r_bub == '0) begin
          w_state_d = StRun;
        end else begin
          w_bub_d = r_bub - {{(BubW-1){1'b0}}, 1'b1};
        end
      end
      StDMiss: begin
        if (i_DCache_Ready) begin
          w_state_d = StRun;
        end
      end
      StIMiss: begin
        // After a preempting D-miss we return via RUN, which re-enters IMISS if still missing.
        if (i_DCache_Miss) begin
          w_state_d = StDMiss;
        end else if (i_ICache_Ready) begin
          w_state_d = StRun;
        end
      end
      default: begin
        w_state_d = StRun;
        w_bub_d   = '0;
      end
    endcase
  end

  assign w_d_act  = (r_state == StDMiss) | i_DCache_Miss;
  assign w_lu_act = (r_state == StLu) | ((r_state == StRun) & i_Need_Stall);
  assign w_i_act  = (r_state == StIMiss) | ((r_state == StRun) & i_ICache_Miss);

  // Output pattern decode, priority D > LU > I > BR; same-cycle response to requests.
  always_comb begin
    o_PC_Stall = 1'b0;
    o_Stall    = '0;
    o_Flush    = '0;
    if (w_d_act) begin
      o_PC_Stall               = 1'b1;
      o_Stall[N_STAGES-2:0]    = '1;
      o_Flush[N_STAGES-1]      = 1'b1;
    end else if (w_lu_act) begin
      o_PC_Stall = 1'b1;
      o_Stall[0] = 1'b1;
      o_Flush[1] = 1'b1;
    end else if (w_i_act) begin
      o_PC_Stall = 1'b1;
      o_Flush[0] = 1'b1;
    end else if (i_Branch_Taken) begin
      o_Flush[1:0] = 2'b11;
    end
  end

  assign o_State = r_state;

`ifdef PIPELINE_STALL_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;

  // Saturating count of cycles with the PC frozen.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_stall_cycles <= '0;
    end else if (o_PC_Stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_Stall_Cycles = r_stall_cycles;
`else
  assign o_Stall_Cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios then random traffic,
// every cycle compared against a flag-based behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int unsigned NStages   = 4;
  localparam int unsigned LuBubbles = 2;
  localparam int unsigned CntW      = 16;

  logic               i_Clk = 1'b0;
  logic               i_Rst_n;
  logic               i_Need_Stall, i_DCache_Miss, i_DCache_Ready;
  logic               i_ICache_Miss, i_ICache_Ready, i_Branch_Taken;
  logic               o_PC_Stall;
  logic [NStages-1:0] o_Stall, o_Flush;
  logic [1:0]         o_State;
  logic [CntW-1:0]    o_Stall_Cycles;

  int n_checks = 0;
  int n_errors = 0;

  // Model: which operation is pending, and how many more LU cycles follow (-1 = none).
  bit     m_dmiss, m_imiss;
  int     m_lu_left;
  longint m_cnt;
  bit     e_pc;

  pipeline_stall_ctrl #(
    .N_STAGES  (NStages),
    .LU_BUBBLES(LuBubbles),
    .CNT_W     (CntW)
  ) u_dut (
    .i_Clk         (i_Clk),
    .i_Rst_n       (i_Rst_n),
    .i_Need_Stall  (i_Need_Stall),
    .i_DCache_Miss (i_DCache_Miss),
    .i_DCache_Ready(i_DCache_Ready),
    .i_ICache_Miss (i_ICache_Miss),
    .i_ICache_Ready(i_ICache_Ready),
    .i_Branch_Taken(i_Branch_Taken),
    .o_PC_Stall    (o_PC_Stall),
    .o_Stall       (o_Stall),
    .o_Flush       (o_Flush),
    .o_State       (o_State),
    .o_Stall_Cycles(o_Stall_Cycles)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dmiss   = 1'b0;
    m_imiss   = 1'b0;
    m_lu_left = -1;
    m_cnt     = 0;
  endtask

  // Compare all outputs with the model for the current inputs.
  task automatic check_outputs();
    bit run, d, lu, i, br;
    logic [31:0] e_state, e_stall, e_flush, e_cycles;
    run = !m_dmiss && !m_imiss && (m_lu_left < 0);
    d   = m_dmiss || i_DCache_Miss;
    lu  = !d && ((m_lu_left >= 0) || (run && i_Need_Stall));
    i   = !d && !lu && (m_imiss || (run && i_ICache_Miss));
    br  = !d && !lu && !i && i_Branch_Taken;
    e_state = m_dmiss ? 2 : m_imiss ? 3 : (m_lu_left >= 0) ? 1 : 0;
    e_pc    = d || lu || i;
    e_stall = d ? ((32'd1 << (NStages - 1)) - 1) : lu ? 32'd1 : 32'd0;
    e_flush = d ? (32'd1 << (NStages - 1)) : lu ? 32'd2 : i ? 32'd1 : br ? 32'd3 : 32'd0;
`ifdef PIPELINE_STALL_CTRL_PERF_CNT_EN
    e_cycles = 32'(m_cnt);
`else
    e_cycles = 32'd0;
`endif
    check_eq("state", 32'(o_State), e_state);
    check_eq("pc_stall", 32'(o_PC_Stall), 32'(e_pc));
    check_eq("stall", 32'(o_Stall), e_stall);
    check_eq("flush", 32'(o_Flush), e_flush);
    check_eq("stall_cycles", 32'(o_Stall_Cycles), e_cycles);
  endtask

  // Advance the model by one clock using the inputs held during that cycle.
  task automatic model_tick(input bit ns, dm, dr, im, ir);
    if (e_pc && (m_cnt < ((64'd1 << CntW) - 1))) m_cnt++;
    if (m_dmiss) begin
      if (dr) m_dmiss = 1'b0;
    end else if (m_imiss) begin
      if (dm) begin
        m_imiss = 1'b0;
        m_dmiss = 1'b1;
      end else if (ir) begin
        m_imiss = 1'b0;
      end
    end else if (m_lu_left >= 0) begin
      if (dm) begin
        m_lu_left = -1;
        m_dmiss   = 1'b1;
      end else begin
        m_lu_left--;
      end
    end else begin
      if (dm) m_dmiss = 1'b1;
      else if (ns) m_lu_left = LuBubbles - 1;
      else if (im) m_imiss = 1'b1;
    end
  endtask

  task automatic step(input bit ns, dm, dr, im, ir, bt);
    i_Need_Stall   = ns;
    i_DCache_Miss  = dm;
    i_DCache_Ready = dr;
    i_ICache_Miss  = im;
    i_ICache_Ready = ir;
    i_Branch_Taken = bt;
    #2;
    check_outputs();
    @(posedge i_Clk);
    model_tick(ns, dm, dr, im, ir);
    #1;
  endtask

  task automatic pulse_reset();
    #1;
    i_Rst_n        = 1'b0;
    i_Need_Stall   = 1'b0;
    i_DCache_Miss  = 1'b0;
    i_DCache_Ready = 1'b0;
    i_ICache_Miss  = 1'b0;
    i_ICache_Ready = 1'b0;
    i_Branch_Taken = 1'b0;
    #1;
    check_eq("rst_state", 32'(o_State), 32'd0);
    check_eq("rst_cycles", 32'(o_Stall_Cycles), 32'd0);
    check_eq("rst_pc_stall", 32'(o_PC_Stall), 32'd0);
    check_eq("rst_flush", 32'(o_Flush), 32'd0);
    model_reset();
    @(posedge i_Clk);
    #1;
    i_Rst_n = 1'b1;
  endtask

  initial begin
    i_Rst_n        = 1'b0;
    i_Need_Stall   = 1'b0;
    i_DCache_Miss  = 1'b0;
    i_DCache_Ready = 1'b0;
    i_ICache_Miss  = 1'b0;
    i_ICache_Ready = 1'b0;
    i_Branch_Taken = 1'b0;
    model_reset();
    #1;
    check_eq("por_state", 32'(o_State), 32'd0);
    check_eq("por_stall", 32'(o_Stall), 32'd0);
    check_eq("por_cycles", 32'(o_Stall_Cycles), 32'd0);
    repeat (2) @(posedge i_Clk);
    #1;
    i_Rst_n = 1'b1;

    // Load-use pulse.
    step(1, 0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    // D-miss for 5 cycles, Ready in the last.
    repeat (4) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    // I-miss preempted by a D-miss.
    repeat (2) step(0, 0, 0, 1, 0, 0);
    repeat (2) step(0, 1, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    repeat (2) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    // Branch against I-miss, then alone.
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    // Load-use aborted by D-miss; stray Ready pulses in RUN.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    // Reset during DMISS, then a stray Ready.
    repeat (2) step(0, 1, 0, 0, 0, 0);
    pulse_reset();
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
      end else begin
        step($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
